// File: rtl/clock_div_pkg.sv
// Shared constants and sizing helper for the multi-channel clock divider.
// Latency: n/a (types and constants only); no backpressure.
package clock_div_pkg;

    localparam int CNT_W_DEF        = 8;
    localparam int DEFAULT_HALF_DEF = 3;

    // A single channel still needs a 1-bit select port.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: counter, active/shadow half-period, pending flag, clk_o and rise_o.
// Latency: outputs registered, 1 cycle from inputs; no backpressure (free-running).
module clock_div_ch
    import clock_div_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             align_i,
    output logic             clk_o,
    output logic             rise_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             pend_q, pend_d;
    logic             at_end, running, apply;

    always_comb begin
        at_end  = (cnt_q == active_q);
        // A high phase always runs to completion, even after en_i drops.
        running = en_i | clk_q;
        // Safe points for a new half-period: falling toggle, idle, or align.
        apply   = align_i | (clk_q & at_end) | ~running;

        cnt_d  = '0;
        clk_d  = 1'b0;
        rise_d = 1'b0;
        if (!align_i && running) begin
            if (at_end) begin
                clk_d  = ~clk_q;
                rise_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                clk_d = clk_q;
            end
        end

        active_d = (apply && pend_q) ? shadow_q : active_q;
        shadow_d = wr_i ? val_i : shadow_q;
        pend_d   = wr_i | (pend_q & ~apply);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            pend_q   <= 1'b0;
            active_q <= RST_HALF;
            shadow_q <= RST_HALF;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            rise_q   <= rise_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
        end
    end

    assign clk_o  = clk_q;
    assign rise_o = rise_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clock_div_multi.sv
// NUM_CH programmable clock dividers with per-channel enable, safe divisor update and global realign.
// Latency: all outputs registered, 1 cycle; no backpressure (writes always accepted).
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int  NUM_CH       = 4,
    parameter int  CNT_W        = CNT_W_DEF,
    parameter int  DEFAULT_HALF = DEFAULT_HALF_DEF,
    localparam int CH_IDX_W     = ch_idx_w(NUM_CH)
) (
    input  logic                iCLK,
    input  logic                RST,
    input  logic                div_wr,
    input  logic [CH_IDX_W-1:0] div_ch,
    input  logic [CNT_W-1:0]    div_val,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                align,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   rise_stb,
    output logic [NUM_CH-1:0]   div_pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;
        // Out-of-range div_ch values match no channel and are dropped.
        assign wr_sel = div_wr && (div_ch == CH_IDX_W'(i));

        clock_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_i   (iCLK),
            .rst_i   (RST),
            .en_i    (ch_en[i]),
            .wr_i    (wr_sel),
            .val_i   (div_val),
            .align_i (align),
            .clk_o   (clk_out[i]),
            .rise_o  (rise_stb[i]),
            .pend_o  (div_pending[i])
        );
    end

endmodule
